// File: rtl/bus_sel_pkg.sv
// Shared types and helpers for the fd-to-fifo bus-select arbitration matrix.
// Optional zero-bubble handover is enabled with the BUS_SEL_BACK2BACK_EN macro.
package bus_sel_pkg;

    localparam int PORT_NUM_DEF = 10;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // fd-major: bit x*P+y is "fd x <-> fifo y" as seen from the fd side.
    function automatic int fd_major_idx(input int x, input int y, input int p);
        return x * p + y;
    endfunction

    // fifo-major: bit y*P+x is "fifo y <-> fd x" as seen from the fifo side.
    function automatic int fifo_major_idx(input int y, input int x, input int p);
        return y * p + x;
    endfunction

endpackage

// File: rtl/bus_sel_rr_arb.sv
// Per-fifo registered round-robin arbiter that locks to one fd until it releases.
// BUS_SEL_BACK2BACK_EN hands the fifo straight to the next requester on release.
module bus_sel_rr_arb
    import bus_sel_pkg::*;
#(
    parameter  int PORT_NUM = PORT_NUM_DEF,
    localparam int IDX_W    = idx_w(PORT_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PORT_NUM-1:0] i_req,
    input  logic [PORT_NUM-1:0] i_eop,
    output logic [IDX_W-1:0]    o_owner,
    output arb_state_t          o_state,
    output logic [PORT_NUM-1:0] o_sel
);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    w_owner_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [IDX_W-1:0]    w_owner_inc;
    logic [IDX_W-1:0]    w_scan_start;
    logic [IDX_W-1:0]    w_pick_idx;
    logic [IDX_W:0]      w_idx;
    logic [PORT_NUM-1:0] w_owner_oh;
    logic [PORT_NUM-1:0] w_cand;
    logic                w_release;
    logic                w_pick_found;

    assign w_owner_oh  = PORT_NUM'(1) << r_owner;
    assign w_owner_inc = (r_owner == IDX_W'(PORT_NUM - 1)) ? '0 : r_owner + IDX_W'(1);
    assign w_release   = (r_state == ST_LOCKED) && (i_eop[r_owner] || !i_req[r_owner]);

    // While locked the scan only matters for handover, so the releasing fd is excluded.
    always_comb begin
        w_scan_start = r_ptr;
        w_cand       = i_req;
        if (r_state == ST_LOCKED) begin
            w_scan_start = w_owner_inc;
            w_cand       = i_req & ~w_owner_oh;
        end
    end

    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        w_idx        = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            w_idx = {1'b0, w_scan_start} + (IDX_W + 1)'(i);
            if (w_idx >= (IDX_W + 1)'(PORT_NUM)) begin
                w_idx = w_idx - (IDX_W + 1)'(PORT_NUM);
            end
            if (!w_pick_found && w_cand[w_idx[IDX_W-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        if (r_state == ST_IDLE) begin
            if (w_pick_found) begin
                w_state_nxt = ST_LOCKED;
                w_owner_nxt = w_pick_idx;
            end
        end else if (w_release) begin
            w_ptr_nxt = w_owner_inc;
`ifdef BUS_SEL_BACK2BACK_EN
            if (w_pick_found) begin
                w_owner_nxt = w_pick_idx;
            end else begin
                w_state_nxt = ST_IDLE;
            end
`else
            w_state_nxt = ST_IDLE;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign o_owner = r_owner;
    assign o_state = r_state;
    assign o_sel   = (r_state == ST_LOCKED) ? w_owner_oh : '0;

endmodule

// File: rtl/bus_sel_arb_matrix.sv
// Square fd-to-fifo bus-select matrix: one registered round-robin arbiter per fifo.
// Define BUS_SEL_BACK2BACK_EN for zero-bubble owner handover on release.
module bus_sel_arb_matrix
    import bus_sel_pkg::*;
#(
    parameter  int PORT_NUM = PORT_NUM_DEF,
    localparam int IDX_W    = idx_w(PORT_NUM)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PORT_NUM*PORT_NUM-1:0] fd_req,
    input  logic [PORT_NUM-1:0]          fd_eop,
    output logic [PORT_NUM*PORT_NUM-1:0] fd_grant,
    output logic [PORT_NUM*PORT_NUM-1:0] fifo_bus_sel,
    output logic [PORT_NUM-1:0]          fifo_busy
);

    // Handshake: an fd holds its request bit until it sees its grant bit; the grant
    // stays up until the fd drops that request or pulses eop, both sampled on clk.
    genvar gy, gx;
    generate
        for (gy = 0; gy < PORT_NUM; gy++) begin : g_fifo
            logic [PORT_NUM-1:0] w_col;
            logic [PORT_NUM-1:0] w_sel;
            logic [IDX_W-1:0]    w_owner;
            arb_state_t          w_state;
            logic                w_busy;

            for (gx = 0; gx < PORT_NUM; gx++) begin : g_fd
                assign w_col[gx] = fd_req[fd_major_idx(gx, gy, PORT_NUM)];
                assign fifo_bus_sel[fifo_major_idx(gy, gx, PORT_NUM)] = w_sel[gx];
                assign fd_grant[fd_major_idx(gx, gy, PORT_NUM)] =
                    w_busy && (w_owner == IDX_W'(gx));
            end

            bus_sel_rr_arb #(
                .PORT_NUM (PORT_NUM)
            ) u_arb (
                .clk     (clk),
                .rst     (rst),
                .i_req   (w_col),
                .i_eop   (fd_eop),
                .o_owner (w_owner),
                .o_state (w_state),
                .o_sel   (w_sel)
            );

            assign w_busy        = (w_state == ST_LOCKED);
            assign fifo_busy[gy] = w_busy;
        end
    endgenerate

endmodule

// File: tb/tb_bus_sel_arb_matrix.sv
// Self-checking bench for bus_sel_arb_matrix (PORT_NUM=10): directed scenarios plus
// randomized traffic, all outputs compared every cycle against a rule-level model.
module tb_bus_sel_arb_matrix;

    localparam int P  = 10;
    localparam int NN = P * P;
    localparam int W  = 2 * NN + P;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic [NN-1:0] fd_req = '0;
    logic [P-1:0]  fd_eop = '0;
    logic [NN-1:0] fd_grant;
    logic [NN-1:0] fifo_bus_sel;
    logic [P-1:0]  fifo_busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b1;

    logic [W-1:0] exp_q[$];

    // Reference model state: per fifo, is it locked, who owns it, where the scan starts.
    bit m_locked[P];
    int m_owner[P];
    int m_ptr[P];

    bus_sel_arb_matrix #(.PORT_NUM(P)) dut (
        .clk          (clk),
        .rst          (rst),
        .fd_req       (fd_req),
        .fd_eop       (fd_eop),
        .fd_grant     (fd_grant),
        .fifo_bus_sel (fifo_bus_sel),
        .fifo_busy    (fifo_busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [NN-1:0] rq(input int x, input int y);
        logic [NN-1:0] v;
        v = '0;
        v[x * P + y] = 1'b1;
        return v;
    endfunction

    function automatic logic [P-1:0] eo(input int x);
        logic [P-1:0] v;
        v = '0;
        v[x] = 1'b1;
        return v;
    endfunction

    function automatic int owner_of(input int y);
        int o;
        o = -1;
        for (int x = 0; x < P; x++) if (fd_grant[x * P + y]) o = x;
        return o;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int y = 0; y < P; y++) begin
            m_locked[y] = 1'b0;
            m_owner[y]  = 0;
            m_ptr[y]    = 0;
        end
    endtask

    function automatic int first_req(input logic [NN-1:0] req, input int y,
                                     input int start, input int skip);
        int x;
        for (int k = 0; k < P; k++) begin
            x = (start + k) % P;
            if (x != skip && req[x * P + y]) return x;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [NN-1:0] req, input logic [P-1:0] eop);
        int w;
        int o;
        for (int y = 0; y < P; y++) begin
            if (!m_locked[y]) begin
                w = first_req(req, y, m_ptr[y], -1);
                if (w >= 0) begin
                    m_locked[y] = 1'b1;
                    m_owner[y]  = w;
                end
            end else begin
                o = m_owner[y];
                if (eop[o] || !req[o * P + y]) begin
                    m_ptr[y]    = (o + 1) % P;
                    m_locked[y] = 1'b0;
`ifdef BUS_SEL_BACK2BACK_EN
                    w = first_req(req, y, (o + 1) % P, o);
                    if (w >= 0) begin
                        m_locked[y] = 1'b1;
                        m_owner[y]  = w;
                    end
`endif
                end
            end
        end
    endtask

    function automatic logic [W-1:0] model_out();
        logic [NN-1:0] g;
        logic [NN-1:0] s;
        logic [P-1:0]  b;
        g = '0;
        s = '0;
        b = '0;
        for (int y = 0; y < P; y++) begin
            b[y] = m_locked[y];
            if (m_locked[y]) begin
                g[m_owner[y] * P + y] = 1'b1;
                s[y * P + m_owner[y]] = 1'b1;
            end
        end
        return {g, s, b};
    endfunction

    always @(posedge clk) begin
        if (rst) model_reset();
        else     model_step(fd_req, fd_eop);
        exp_q.push_back(model_out());
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty t=%0t actual=0 entries required=1 entry", $time);
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (fd_grant !== e[W-1 -: NN]) begin
                    n_fail++;
                    $display("FAIL sb_fd_grant t=%0t actual=%h required=%h",
                             $time, fd_grant, e[W-1 -: NN]);
                end
                n_checks++;
                if (fifo_bus_sel !== e[NN+P-1 -: NN]) begin
                    n_fail++;
                    $display("FAIL sb_fifo_bus_sel t=%0t actual=%h required=%h",
                             $time, fifo_bus_sel, e[NN+P-1 -: NN]);
                end
                n_checks++;
                if (fifo_busy !== e[P-1:0]) begin
                    n_fail++;
                    $display("FAIL sb_fifo_busy t=%0t actual=%h required=%h",
                             $time, fifo_busy, e[P-1:0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic [NN-1:0] req, input logic [P-1:0] eop);
        @(negedge clk);
        #1;
        fd_req = req;
        fd_eop = eop;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rel_expect(input logic [NN-1:0] req, input int y, input int own,
                              input int nxt, input string nm);
        drive(req, eo(own));
        tick();
`ifdef BUS_SEL_BACK2BACK_EN
        check({nm, "_handover"}, owner_of(y), nxt);
        drive(req, '0);
`else
        check({nm, "_bubble"}, fifo_busy[y], 0);
        drive(req, '0);
        tick();
        check({nm, "_owner"}, owner_of(y), nxt);
`endif
    endtask

    task automatic rand_req(output logic [NN-1:0] v);
        for (int i = 0; i < NN; i++) v[i] = $urandom_range(0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NN-1:0] req;
        logic [NN-1:0] rv;
        logic [P-1:0]  ev;

        // Reset holds everything at zero whatever the requests are.
        for (int c = 0; c < 3; c++) begin
            rand_req(rv);
            drive(rv, '0);
            tick();
            check("rst_grant", 32'(|fd_grant), 0);
            check("rst_sel", 32'(|fifo_bus_sel), 0);
            check("rst_busy", 32'(|fifo_busy), 0);
        end
        @(negedge clk);
        #1;
        rst    = 1'b0;
        fd_req = '0;
        tick();

        // First grant after reset: fd 3 -> fifo 7, registered one cycle.
        drive(rq(3, 7), '0);
        check("lat_no_comb_path", fifo_busy[7], 0);
        tick();
        check("first_sel_73", fifo_bus_sel[73], 1);
        check("first_grant_37", fd_grant[37], 1);
        check("first_busy_7", fifo_busy[7], 1);
        drive('0, '0);
        tick();

        // Round-robin on fifo 0 among fds 2, 5, 9: order 2, 5, 9, 2.
        req = rq(2, 0) | rq(5, 0) | rq(9, 0);
        drive(req, '0);
        tick();
        check("rr_first", owner_of(0), 2);
        rel_expect(req, 0, 2, 5, "rr_2to5");
        rel_expect(req, 0, 5, 9, "rr_5to9");
        rel_expect(req, 0, 9, 2, "rr_9to2");
        drive('0, '0);
        tick();

        // Pointer wrap on fifo 1: owner 8 releases, then 9 beats 1, then 1 after wrap.
        drive(rq(8, 1), '0);
        tick();
        check("wrap_owner8", owner_of(1), 8);
        drive('0, eo(8));
        tick();
        check("wrap_idle", fifo_busy[1], 0);
        req = rq(1, 1) | rq(9, 1);
        drive(req, '0);
        tick();
        check("wrap_owner9", owner_of(1), 9);
        rel_expect(req, 1, 9, 1, "wrap_9to1");
        drive('0, '0);
        tick();
        tick();

        // Multicast: fd 4 owns fifos 0, 1, 6 together and one eop frees all three.
        req = rq(4, 0) | rq(4, 1) | rq(4, 6);
        drive(req, '0);
        tick();
        check("mc_grant0", fd_grant[40], 1);
        check("mc_grant1", fd_grant[41], 1);
        check("mc_grant6", fd_grant[46], 1);
        drive(req, eo(4));
        tick();
        check("mc_busy_after_eop", 32'({fifo_busy[6], fifo_busy[1], fifo_busy[0]}), 0);
        drive('0, '0);
        tick();

        // Release by dropping the request: fd 6 leaves fifo 2, pending fd 0 takes it.
        drive(rq(6, 2), '0);
        tick();
        check("drop_owner6", owner_of(2), 6);
        drive(rq(6, 2) | rq(0, 2), '0);
        tick();
        check("drop_pending_held", owner_of(2), 6);
        drive(rq(0, 2), '0);
        tick();
`ifdef BUS_SEL_BACK2BACK_EN
        check("drop_handover0", owner_of(2), 0);
`else
        check("drop_bubble", fifo_busy[2], 0);
        tick();
        check("drop_owner0", owner_of(2), 0);
`endif
        drive('0, '0);
        tick();

        // Async reset mid-lock: fifo 3 pointer advanced first, then reset must clear it.
        drive(rq(3, 3), '0);
        tick();
        check("ar_owner3", owner_of(3), 3);
        drive('0, eo(3));
        tick();
        drive(rq(3, 3) | rq(5, 5), '0);
        tick();
        check("ar_locked", 32'({fifo_busy[5], fifo_busy[3]}), 3);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("ar_grant_zero", 32'(|fd_grant), 0);
        check("ar_sel_zero", 32'(|fifo_bus_sel), 0);
        check("ar_busy_zero", 32'(|fifo_busy), 0);
        tick();
        @(negedge clk);
        #1;
        rst    = 1'b0;
        fd_req = rq(1, 3) | rq(5, 3);
        fd_eop = '0;
        tick();
        check("ar_ptr_reset", owner_of(3), 1);
        drive('0, '0);
        tick();

        // Randomized traffic: slowly varying requests, sparse eops, rare resets.
        rv = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NN; i++) if ($urandom_range(0, 7) == 0) rv[i] = ~rv[i];
            for (int x = 0; x < P; x++) ev[x] = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            #1;
            rst    = ($urandom_range(0, 99) == 0);
            fd_req = rv;
            fd_eop = ev;
        end
        @(negedge clk);
        #1;
        rst    = 1'b0;
        fd_req = '0;
        fd_eop = '0;
        tick();
        tick();
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_sel_arb_matrix.md
Name: bus_sel_arb_matrix

Overview:
- Parametrised successor to the flat fd-to-fifo bus-select transpose.
- Each of PORT_NUM frame dispatchers (fd) raises a request bitmask over PORT_NUM fifos. Each fifo independently runs a registered round-robin arbiter and locks to one owner fd until that fd releases.
- Drives the transposed one-hot select into each fifo and the matching grant matrix back to each fd.
- Sits between the fd array and the fifo array in place of the combinational interconnect.

Parameters:
- PORT_NUM, 10, number of fds and number of fifos (square matrix); legal range 2..32.
- IDX_W, $clog2(PORT_NUM), width of owner and pointer indices; derived, not overridden.

Ports:
- clk  in  1  single clock; all flops rising-edge.
- rst  in  1  asynchronous, active-high reset.
- fd_req  in  PORT_NUM*PORT_NUM  bit [x*PORT_NUM+y] = fd x requests fifo y.
- fd_eop  in  PORT_NUM  bit x = fd x ends its packet; releases every fifo fd x owns.
- fd_grant  out  PORT_NUM*PORT_NUM  bit [x*PORT_NUM+y] = fd x owns fifo y.
- fifo_bus_sel  out  PORT_NUM*PORT_NUM  bit [y*PORT_NUM+x] = fifo y selects fd x; one-hot or zero per fifo.
- fifo_busy  out  PORT_NUM  bit y = fifo y locked.

Behaviour:
- Reset: all fifos IDLE; owner=0; rr_ptr=0. fd_grant, fifo_bus_sel and fifo_busy are all 0.
- Per-fifo FSM, two states:
  - IDLE to LOCKED when any fd x has fd_req[x*P+y]=1. Owner = first requester scanning x = rr_ptr, rr_ptr+1, ... modulo PORT_NUM.
  - LOCKED to IDLE when the owner's fd_eop=1, or the owner's request bit for this fifo is 0. On this transition rr_ptr = (owner+1) mod PORT_NUM.
- Latency:
  - A request sampled at edge N produces a grant visible after edge N (registered, 1 cycle).
  - Release sampled at edge N drops the grant after edge N.
- Outputs are pure decodes of registered state: fifo_bus_sel[y*P+x] = fd_grant[x*P+y] = LOCKED_y && owner_y==x. No combinational input-to-output path.
- Non-owner requests to a LOCKED fifo are held pending. They are not dropped and not flagged.
- One fd may own several fifos at once (multicast); each fifo arbitrates independently.
- One fd_eop releases all fifos owned by that fd in the same cycle. fd_eop from a non-owner has no effect.
- fd_eop and fd_req both high from the same owner in the release cycle: release wins, and the fd re-requests normally.
- Release and new requests in the same cycle: fifo goes IDLE for one cycle and arbitrates on the next edge (1-cycle bubble, unless the optional feature is enabled).
- rr_ptr wraps from PORT_NUM-1 to 0. Pointer values >= PORT_NUM are unreachable.
- Reset mid-lock clears ownership immediately (asynchronous); grants drop without an eop.

Optional Feature:
- Macro BUS_SEL_BACK2BACK_EN.
- Defined: in the release cycle the fifo arbitrates among the remaining requesters, excluding the releasing fd, starting from (owner+1) mod PORT_NUM. If any exist it stays LOCKED with the new owner (zero bubble); otherwise it goes IDLE.
- Undefined: the 1-cycle IDLE bubble above applies.

Decomposition:
- Package bus_sel_pkg: PORT_NUM default, IDX_W function, state enum (IDLE, LOCKED), flat-index helper functions for fd-major and fifo-major bit positions.
- Sub-module bus_sel_rr_arb: one instance per fifo via generate. Inputs are the PORT_NUM-bit request column and the eop vector; outputs are owner, locked and one-hot select.
- Top level only slices columns and transposes outputs.

Test Plan (PORT_NUM=10):
- Reset: rst=1 with random fd_req -> all outputs 0. Release rst, fd 3 requests fifo 7 -> one cycle later fifo_bus_sel[73]=1, fd_grant[37]=1, fifo_busy[7]=1.
- Round-robin: fds 2, 5, 9 hold requests on fifo 0; fd_eop pulsed by each owner in turn -> grant order 2, 5, 9, 2. Exactly one IDLE cycle between owners without the macro, none with it.
- Wrap: rr_ptr=9 after owner 8 releases; fds 1 and 9 request -> fd 9 granted. After 9 releases, fd 1 granted (pointer wrapped to 0).
- Multicast: fd 4 requests fifos 0, 1 and 6 while idle -> all three grant fd 4 in the same cycle. One fd_eop[4] -> all three drop together.
- Drop without eop: owner fd 6 deasserts its fifo 2 request -> fifo_busy[2]=0 next cycle; pending fd 0 is granted the cycle after (or the same cycle with BUS_SEL_BACK2BACK_EN).
- Async reset mid-lock: rst asserted between edges while fifos 3 and 5 are locked -> outputs 0 without waiting for clk; rr_ptr=0 after release.
